// File: rtl/srl_fifo.sv
// srl_fifo: first-word-fall-through FIFO made of an addressable shift-register
// column (SRL16E style) and one output register.
//
// Each accepted write shifts the column, so slot 0 always holds the newest
// word. The read side taps the oldest word at address srl_cnt-1 and moves it
// into the output register whenever that register is free or being consumed.
// Total capacity is DEPTH+1 words.
//
// Ports:
//   CLK    in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   wr_en  in   write request (ignored while full)
//   din    in   write data
//   full   out  SRL column holds DEPTH words
//   rd_en  in   read request (ignored while empty)
//   dout   out  head-of-queue word, valid while empty is low
//   empty  out  output register holds no word
//   count  out  total words held (SRL + output register)

module srl_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [4:0]       count
);

  // The physical column is always 16 deep; DEPTH only limits how far it fills.
  logic [WIDTH-1:0] srl_q [16];

  logic [4:0]       srl_cnt_q, srl_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic [3:0]       tap_addr;
  logic [WIDTH-1:0] tap_data;
  logic             wr_acc;
  logic             rd_acc;
  logic             load;

  always_comb begin
    full     = (srl_cnt_q == 5'(DEPTH));
    wr_acc   = wr_en & ~full;
    rd_acc   = rd_en & out_valid_q;
    // Address is meaningless when srl_cnt is 0; load is blocked then anyway.
    tap_addr = 4'(srl_cnt_q - 5'd1);
    tap_data = srl_q[tap_addr];
    load     = (srl_cnt_q != 5'd0) & (~out_valid_q | rd_acc);

    srl_cnt_d   = srl_cnt_q + {4'd0, wr_acc} - {4'd0, load};
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    if (load) begin
      // Tap is read before this edge's shift, so a simultaneous write cannot
      // overtake the word being loaded.
      dout_d      = tap_data;
      out_valid_d = 1'b1;
    end else if (rd_acc) begin
      out_valid_d = 1'b0;
    end
  end

  // Storage has no reset: stale contents are never addressed once srl_cnt is 0.
  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      srl_q[0] <= din;
      for (int i = 1; i < 16; i++) begin
        srl_q[i] <= srl_q[i-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      srl_cnt_q   <= 5'd0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      srl_cnt_q   <= srl_cnt_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
    end
  end

  assign dout  = dout_q;
  assign empty = ~out_valid_q;
  assign count = srl_cnt_q + {4'd0, out_valid_q};

endmodule

// File: tb/tb_srl_fifo.sv
module tb_srl_fifo;

  logic        CLK;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] din;
  logic        full;
  logic        rd_en;
  logic [31:0] dout;
  logic        empty;
  logic [4:0]  count;

  int errors = 0;
  int checks = 0;

  srl_fifo #(.WIDTH(32), .DEPTH(16)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .din   (din),
    .full  (full),
    .rd_en (rd_en),
    .dout  (dout),
    .empty (empty),
    .count (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    wr_en = 1'b0; rd_en = 1'b0; din = '0;
    do_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", full); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (dout !== 32'd0) begin errors++; $display("FAIL reset_dout got=%h exp=0", dout); end
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1; tick(); rd_en = 1'b0; tick();
    end
    checks++; if ({empty, full, count, dout} !== {1'b1, 1'b0, 5'd0, 32'd0}) begin
      errors++; $display("FAIL idle_rd e=%0b f=%0b c=%0d d=%h exp e=1 f=0 c=0 d=0", empty, full, count, dout);
    end
  endtask

  task automatic test_single_word();
    wr_en = 1'b1; din = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0; din = '0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lat_cycle1_empty got=%0b exp=1", empty); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL lat_cycle1_count got=%0d exp=1", count); end
    tick();
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL lat_cycle2_empty got=%0b exp=0", empty); end
    checks++; if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL lat_cycle2_dout got=%h exp=deadbeef", dout); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL lat_cycle2_count got=%0d exp=1", count); end
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_read_empty got=%0b exp=1", empty); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_read_count got=%0d exp=0", count); end
  endtask

  task automatic test_fill();
    // Word k is written in cycle k-1; word 17 lands at the edge ending cycle 16.
    for (int k = 1; k <= 20; k++) begin
      wr_en = 1'b1; din = k;
      if (k == 17) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_not_full_early got=%0b exp=0", full); end
      end
      tick();
      if (k == 17) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%0b exp=1", full); end
      end
    end
    wr_en = 1'b0;
    checks++; if (count !== 5'd17) begin errors++; $display("FAIL fill_count got=%0d exp=17", count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full_held got=%0b exp=1", full); end
    rd_en = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      checks++; if (empty !== 1'b0 || dout !== 32'(k)) begin
        errors++; $display("FAIL drain_word%0d got=%0d empty=%0b exp=%0d", k, dout, empty, k);
      end
      tick();
    end
    rd_en = 1'b0;
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin
      errors++; $display("FAIL drain_end empty=%0b count=%0d exp empty=1 count=0", empty, count);
    end
  endtask

  task automatic test_back_to_back();
    // Four primed words leave srl_cnt=3 plus a loaded output register.
    for (int k = 0; k < 4; k++) begin
      wr_en = 1'b1; din = 32'h100 + k; tick();
    end
    wr_en = 1'b0;
    tick(); tick();
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL b2b_prime_count got=%0d exp=4", count); end
    for (int i = 0; i < 50; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; din = 32'h104 + i;
      checks++; if (empty !== 1'b0 || dout !== 32'h100 + i || count !== 5'd4) begin
        errors++; $display("FAIL b2b_step%0d dout=%h empty=%0b count=%0d exp dout=%h empty=0 count=4",
                           i, dout, empty, count, 32'h100 + i);
      end
      tick();
    end
    wr_en = 1'b0;
    for (int i = 50; i < 54; i++) begin
      checks++; if (empty !== 1'b0 || dout !== 32'h100 + i) begin
        errors++; $display("FAIL b2b_tail%0d dout=%h empty=%0b exp dout=%h", i, dout, empty, 32'h100 + i);
      end
      tick();
    end
    rd_en = 1'b0;
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin
      errors++; $display("FAIL b2b_end empty=%0b count=%0d exp 1/0", empty, count);
    end
  endtask

  task automatic test_full_read();
    for (int k = 0; k < 17; k++) begin
      wr_en = 1'b1; din = 32'h200 + k; tick();
    end
    checks++; if (count !== 5'd17 || full !== 1'b1) begin
      errors++; $display("FAIL fr_setup count=%0d full=%0b exp 17/1", count, full);
    end
    wr_en = 1'b1; rd_en = 1'b1; din = 32'hBAD0BAD0;
    tick();
    rd_en = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fr_count got=%0d exp=16", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL fr_full got=%0b exp=0", full); end
    checks++; if (dout !== 32'h201) begin errors++; $display("FAIL fr_dout got=%h exp=201", dout); end
    wr_en = 1'b1; din = 32'h300;
    tick();
    wr_en = 1'b0;
    checks++; if (count !== 5'd17 || full !== 1'b1) begin
      errors++; $display("FAIL fr_next_write count=%0d full=%0b exp 17/1", count, full);
    end
    // Remaining order: 0x201..0x210 then 0x300; the dropped write must not appear.
    rd_en = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      checks++; if (dout !== ((k == 17) ? 32'h300 : 32'h200 + k) || empty !== 1'b0) begin
        errors++; $display("FAIL fr_drain%0d got=%h empty=%0b exp=%h", k, dout, empty,
                           (k == 17) ? 32'h300 : 32'h200 + k);
      end
      tick();
    end
    rd_en = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fr_drain_end got=%0b exp=1", empty); end
  endtask

  task automatic test_reset_mid_stream();
    for (int k = 0; k < 9; k++) begin
      wr_en = 1'b1; din = 32'h400 + k; tick();
    end
    wr_en = 1'b0;
    checks++; if (count !== 5'd9) begin errors++; $display("FAIL rm_setup count=%0d exp=9", count); end
    rst_n = 1'b0; wr_en = 1'b1; rd_en = 1'b1; din = 32'hFFFF0000;
    tick();
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (empty !== 1'b1 || count !== 5'd0 || full !== 1'b0) begin
      errors++; $display("FAIL rm_after_reset empty=%0b count=%0d full=%0b exp 1/0/0", empty, count, full);
    end
    wr_en = 1'b1; din = 32'h5A5A5A5A;
    tick();
    wr_en = 1'b0;
    tick();
    checks++; if (empty !== 1'b0 || dout !== 32'h5A5A5A5A || count !== 5'd1) begin
      errors++; $display("FAIL rm_first_word dout=%h empty=%0b count=%0d exp 5a5a5a5a/0/1", dout, empty, count);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin
      errors++; $display("FAIL rm_only_word empty=%0b count=%0d exp 1/0", empty, count);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    test_reset();
    test_single_word();
    test_fill();
    test_back_to_back();
    test_full_read();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
